// File: rtl/piezo_pkg.sv
// piezo_pkg: shared types and default timing constants for the piezo alert
// sequencer.
//   pz_mode_t  - cadence select (continuous, beep, double-beep, siren)
//   pz_state_t - sequencer FSM states
//   PZ_*_50M   - default phase durations in clk cycles at 50 MHz
package piezo_pkg;

  typedef enum logic [1:0] {
    PZ_CONT,
    PZ_BEEP,
    PZ_DBL,
    PZ_SIREN
  } pz_mode_t;

  typedef enum logic [2:0] {
    PZ_IDLE,
    PZ_TONE1,
    PZ_GAP,
    PZ_TONE2,
    PZ_REST
  } pz_state_t;

  // 250 ms tone, 250 ms rest, 50 ms inter-tone gap at 50 MHz.
  localparam int PZ_BEEP_ON_50M  = 12_500_000;
  localparam int PZ_BEEP_OFF_50M = 12_500_000;
  localparam int PZ_GAP_CYC_50M  = 2_500_000;

endpackage : piezo_pkg

// File: rtl/piezo_seq_tone_div.sv
// tone_div: square-wave tone generator.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear of counter and tone (highest priority)
//   run        - count enable
//   half_per   - half-period H in clk cycles; 0 holds the tone low
//   tone       - output flop; toggles every H counted cycles (period 2H)
module tone_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] half_per,
  output logic             tone
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;
  logic             term;

  assign term = (cnt_q == (half_per - DIV_W'(1)));

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clr || (half_per == '0)) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (run) begin
      if (term) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d  = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule : tone_div

// File: rtl/piezo_seq.sv
// piezo_seq: piezo alert sequencer with selectable tone and cadence.
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - level request; low forces IDLE immediately (next edge)
//   mode        - cadence: 0 CONT, 1 BEEP, 2 DBL, 3 SIREN
//   half_per_a  - primary tone half-period (clk cycles), 0 = silent
//   half_per_b  - second tone half-period, SIREN only
//   buzz/buzz_n - piezo drive and its complement
//   active      - high while out of IDLE
//   cycle_done  - one-cycle pulse on each cadence-boundary entry into TONE1
// mode and half-periods are shadowed on entry into TONE1 (from IDLE or at a
// cadence boundary); all sequencing uses the shadow copies.
module piezo_seq
  import piezo_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int CAD_W    = 24,
  parameter int BEEP_ON  = PZ_BEEP_ON_50M,
  parameter int BEEP_OFF = PZ_BEEP_OFF_50M,
  parameter int GAP_CYC  = PZ_GAP_CYC_50M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] half_per_a,
  input  logic [DIV_W-1:0] half_per_b,
  output logic             buzz,
  output logic             buzz_n,
  output logic             active,
  output logic             cycle_done
);

  localparam logic [CAD_W-1:0] ON_LAST  = CAD_W'(BEEP_ON - 1);
  localparam logic [CAD_W-1:0] OFF_LAST = CAD_W'(BEEP_OFF - 1);
  localparam logic [CAD_W-1:0] GAP_LAST = CAD_W'(GAP_CYC - 1);

  pz_state_t        state_q, state_d, seq_next;
  logic [CAD_W-1:0] cad_q, cad_d, last_cnt;
  pz_mode_t         mode_q, mode_d;
  logic [DIV_W-1:0] ha_q, ha_d, hb_q, hb_d;
  logic             active_q, active_d;
  logic             cd_q, cd_d;
  logic             at_end, capture;
  logic             tone_clr, tone_run;
  logic [DIV_W-1:0] tone_hp;
  logic             tone;

  // Terminal cadence count of the current phase.
  always_comb begin
    last_cnt = ON_LAST;
    case (state_q)
      PZ_GAP:  last_cnt = GAP_LAST;
      PZ_REST: last_cnt = OFF_LAST;
      default: last_cnt = ON_LAST;
    endcase
  end

  assign at_end = (state_q != PZ_IDLE) && (cad_q == last_cnt);

  // Successor at a cadence boundary, chosen from the shadow mode.
  always_comb begin
    seq_next = PZ_IDLE;
    case (state_q)
      PZ_TONE1: begin
        case (mode_q)
          PZ_CONT:  seq_next = PZ_TONE1;
          PZ_BEEP:  seq_next = PZ_REST;
          PZ_DBL:   seq_next = PZ_GAP;
          PZ_SIREN: seq_next = PZ_TONE2;
          default:  seq_next = PZ_TONE1;
        endcase
      end
      PZ_GAP:   seq_next = PZ_TONE2;
      PZ_TONE2: seq_next = (mode_q == PZ_SIREN) ? PZ_TONE1 : PZ_REST;
      PZ_REST:  seq_next = PZ_TONE1;
      default:  seq_next = PZ_IDLE;
    endcase
  end

  // Next state. Every entry (including CONT's TONE1 re-entry) clears both
  // counters and the tone flop; en low outranks everything.
  always_comb begin
    state_d  = state_q;
    cad_d    = cad_q;
    capture  = 1'b0;
    cd_d     = 1'b0;
    tone_clr = 1'b0;
    if (!en) begin
      state_d  = PZ_IDLE;
      cad_d    = '0;
      tone_clr = 1'b1;
    end else if (state_q == PZ_IDLE) begin
      state_d  = PZ_TONE1;
      cad_d    = '0;
      capture  = 1'b1;
      tone_clr = 1'b1;
    end else if (at_end) begin
      state_d  = seq_next;
      cad_d    = '0;
      tone_clr = 1'b1;
      if (seq_next == PZ_TONE1) begin
        capture = 1'b1;
        cd_d    = 1'b1;
      end
    end else begin
      cad_d = cad_q + CAD_W'(1);
    end
  end

  always_comb begin
    mode_d   = capture ? pz_mode_t'(mode) : mode_q;
    ha_d     = capture ? half_per_a : ha_q;
    hb_d     = capture ? half_per_b : hb_q;
    active_d = (state_d != PZ_IDLE);
  end

  assign tone_run = (state_q == PZ_TONE1) || (state_q == PZ_TONE2);
  assign tone_hp  = ((state_q == PZ_TONE2) && (mode_q == PZ_SIREN)) ? hb_q : ha_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PZ_IDLE;
      cad_q    <= '0;
      mode_q   <= PZ_CONT;
      ha_q     <= '0;
      hb_q     <= '0;
      active_q <= 1'b0;
      cd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cad_q    <= cad_d;
      mode_q   <= mode_d;
      ha_q     <= ha_d;
      hb_q     <= hb_d;
      active_q <= active_d;
      cd_q     <= cd_d;
    end
  end

  tone_div #(
    .DIV_W (DIV_W)
  ) u_tone_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tone_clr),
    .run      (tone_run),
    .half_per (tone_hp),
    .tone     (tone)
  );

  assign buzz       = tone;
  assign buzz_n     = ~tone;
  assign active     = active_q;
  assign cycle_done = cd_q;

endmodule : piezo_seq

// File: tb/tb_piezo_seq.sv
// tb_piezo_seq: directed bench for piezo_seq with short cadence durations
// (tone 20, rest 10, gap 5). Inputs change and outputs are sampled on the
// falling clock edge; expected waveforms are derived from the cadence layout
// and the elapsed edge count t since the IDLE->TONE1 edge.
module tb_piezo_seq;
  import piezo_pkg::*;

  localparam int TB_DIV_W = 16;
  localparam int TB_CAD_W = 24;
  localparam int TB_ON    = 20;
  localparam int TB_OFF   = 10;
  localparam int TB_GAP   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [1:0]          mode;
  logic [TB_DIV_W-1:0] half_per_a, half_per_b;
  logic                buzz, buzz_n, active, cycle_done;

  int n_cmp = 0;
  int n_err = 0;

  piezo_seq #(
    .DIV_W    (TB_DIV_W),
    .CAD_W    (TB_CAD_W),
    .BEEP_ON  (TB_ON),
    .BEEP_OFF (TB_OFF),
    .GAP_CYC  (TB_GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .half_per_a (half_per_a),
    .half_per_b (half_per_b),
    .buzz       (buzz),
    .buzz_n     (buzz_n),
    .active     (active),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {buzz, cycle_done} t edges after the IDLE->TONE1 edge.
  function automatic logic [1:0] model(input int md, input int ha, input int hb, input int t);
    int   per, p, j, h;
    logic tone_on, b, cd;
    tone_on = 1'b0;
    j = 0;
    h = ha;
    case (md)
      0:       per = TB_ON;
      1:       per = TB_ON + TB_OFF;
      2:       per = 2 * TB_ON + TB_GAP + TB_OFF;
      default: per = 2 * TB_ON;
    endcase
    p  = t % per;
    cd = (p == 0) && (t > 0);
    case (md)
      0: begin tone_on = 1'b1; j = p; end
      1: if (p < TB_ON) begin tone_on = 1'b1; j = p; end
      2: begin
        if (p < TB_ON) begin
          tone_on = 1'b1; j = p;
        end else if ((p >= TB_ON + TB_GAP) && (p < 2 * TB_ON + TB_GAP)) begin
          tone_on = 1'b1; j = p - TB_ON - TB_GAP;
        end
      end
      default: begin
        tone_on = 1'b1;
        if (p < TB_ON) j = p;
        else begin j = p - TB_ON; h = hb; end
      end
    endcase
    if (!tone_on || h == 0) b = 1'b0;
    else b = ((j / h) % 2) == 1;
    return {b, cd};
  endfunction

  task automatic run_chk(input int md, input int ha, input int hb, input int t0, input int n);
    logic [1:0] e;
    logic       eb;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e  = model(md, ha, hb, t0 + i);
      eb = e[1];
      check_eq("buzz", buzz, eb);
      check_eq("buzz_n", buzz_n, !eb);
      check_eq("active", active, 1);
      check_eq("cycle_done", cycle_done, e[0]);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".buzz"}, buzz, 0);
    check_eq({tag, ".buzz_n"}, buzz_n, 1);
    check_eq({tag, ".active"}, active, 0);
    check_eq({tag, ".cycle_done"}, cycle_done, 0);
  endtask

  task automatic go_idle();
    en = 1'b0;
    @(negedge clk);
    check_quiet("idle");
  endtask

  task automatic start(input pz_mode_t md, input int ha, input int hb);
    mode       = md;
    half_per_a = TB_DIV_W'(ha);
    half_per_b = TB_DIV_W'(hb);
    en         = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b1;
    en         = 1'b0;
    mode       = 2'd0;
    half_per_a = '0;
    half_per_b = '0;

    if (TB_ON < 1 || TB_OFF < 1 || TB_GAP < 1 ||
        TB_ON >= (1 << TB_CAD_W) || TB_OFF >= (1 << TB_CAD_W) || TB_GAP >= (1 << TB_CAD_W)) begin
      $display("FAIL durations: illegal bench duration parameters");
      $fatal(1, "illegal durations");
    end

    // Reset, then 50 idle cycles with en low.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_quiet("hold");
    end

    // CONT, H=3.
    start(PZ_CONT, 3, 0);
    run_chk(0, 3, 0, 0, 65);
    go_idle();

    // BEEP, H=2.
    start(PZ_BEEP, 2, 0);
    run_chk(1, 2, 0, 0, 65);
    go_idle();

    // DBL, H=2.
    start(PZ_DBL, 2, 0);
    run_chk(2, 2, 0, 0, 115);
    go_idle();

    // SIREN a=2 b=5; mode->CONT mid-TONE1 waits for the boundary at t=40.
    start(PZ_SIREN, 2, 5);
    run_chk(3, 2, 5, 0, 6);
    mode = PZ_CONT;
    run_chk(3, 2, 5, 6, 34);
    run_chk(0, 2, 5, 20, 30);
    // half_per_a=0 mid-tone: takes effect only at the next boundary.
    half_per_a = '0;
    run_chk(0, 2, 5, 50, 10);
    run_chk(0, 0, 5, 60, 40);
    go_idle();

    // en dropped mid-TONE2 of a siren.
    start(PZ_SIREN, 2, 5);
    run_chk(3, 2, 5, 0, 30);
    go_idle();

    // Asynchronous reset mid-TONE1, then restart with en still high.
    start(PZ_CONT, 3, 0);
    run_chk(0, 3, 0, 0, 10);
    #2 rst_n = 1'b0;
    #1 check_quiet("async_rst");
    @(negedge clk);
    check_quiet("rst_held");
    rst_n = 1'b1;
    run_chk(0, 3, 0, 0, 25);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_piezo_seq

// File: doc/piezo_seq.md
# piezo_seq

Parametrised piezo alert sequencer: the next generation of the digital core's fixed-divide buzzer. It generates a square-wave drive on `buzz`/`buzz_n` with a runtime-selectable half-period and a cadence mode (continuous, beep, double-beep, two-tone siren). It sits in `dig_core`, enabled by the obstacle-stop condition `in_transit & ~OK2Move`, and reports cadence boundaries for status logic.

## Interface
- `DIV_W`, default 16: width of the tone half-period counter and inputs.
- `CAD_W`, default 24: width of the cadence counter.
- `BEEP_ON`, default 12_500_000: cycles per tone phase (250 ms at 50 MHz).
- `BEEP_OFF`, default 12_500_000: cycles per rest phase.
- `GAP_CYC`, default 2_500_000: cycles of silence between the two tones of a double-beep.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: level request; high means sound the alert.
- `mode` input 2: cadence select. 0 = CONT, 1 = BEEP, 2 = DBL, 3 = SIREN.
- `half_per_a` input DIV_W: primary tone half-period in clk cycles.
- `half_per_b` input DIV_W: second tone half-period; used only in SIREN.
- `buzz` output 1: piezo drive.
- `buzz_n` output 1: complement of `buzz`.
- `active` output 1: high while the sequencer is out of IDLE.
- `cycle_done` output 1: one-cycle pulse at each cadence-period boundary.

## Operation
- States: IDLE, TONE1, GAP, TONE2, REST.
- Every state entry clears the tone counter and the cadence counter, and forces `buzz` to 0.
- A state lasts exactly its duration D, leaving when the cadence counter reaches D-1.
- Phase durations:
  - TONE1 and TONE2: `BEEP_ON`.
  - GAP: `GAP_CYC`.
  - REST: `BEEP_OFF`.
- Transitions by mode:
  - CONT: TONE1 → TONE1 (re-entry every `BEEP_ON`; no audible break other than the phase restart).
  - BEEP: TONE1 → REST → TONE1.
  - DBL: TONE1 → GAP → TONE2 → REST → TONE1.
  - SIREN: TONE1 → TONE2 → TONE1.
- IDLE → TONE1 when `en` is high. Any state → IDLE when `en` is low; this has priority over all other transitions.
- Shadow registers capture `mode`, `half_per_a` and `half_per_b`:
  - on IDLE → TONE1;
  - on every cadence-boundary entry into TONE1.
- Input changes at any other time have no effect until the next capture. All sequencing uses shadow values only.
- Tone divider in TONE1/TONE2 with half-period H:
  - counts 0..H-1;
  - at H-1 it toggles `buzz` and wraps to 0;
  - gives a buzz period of 2H cycles.
- TONE2 uses the shadow `half_per_b` in SIREN and the shadow `half_per_a` otherwise.
- H = 0 means silent: `buzz` is held at 0, cadence still runs, `active` stays high.
- `buzz` is 0 in IDLE, GAP and REST.
- `cycle_done` is registered and high for exactly the first cycle of a TONE1 entered from TONE1, TONE2 or REST. It is never asserted on entry from IDLE.
- `active` is registered and equals (state != IDLE).
- Durations of 0 are illegal; the bench asserts `BEEP_ON`, `BEEP_OFF` and `GAP_CYC` are all ≥ 1 and < 2^CAD_W.

## Timing
- Reset values: state IDLE, `buzz` 0, `buzz_n` 1, `active` 0, `cycle_done` 0, all counters 0, shadows 0.
- Reset assertion mid-sequence takes effect asynchronously; after release the block restarts from IDLE.
- `en` high sampled at edge k:
  - `active` = 1 after edge k;
  - first `buzz` rise at edge k+H.
- `en` low sampled at edge k: after edge k, `buzz` = 0 and `active` = 0.
- A toggle due on the same edge as a state exit is suppressed; the entry clear wins.
- `buzz_n` is the combinational inverse of the `buzz` flop, so the pair never overlaps.
- No handshake: `en` is a level input, and `cycle_done` is informational with no acknowledge.

## Structure
- `piezo_pkg`:
  - `typedef enum logic [1:0] {PZ_CONT, PZ_BEEP, PZ_DBL, PZ_SIREN} pz_mode_t`;
  - the state enum `pz_state_t`;
  - default duration constants for 50 MHz.
- Sub-module `tone_div`:
  - parameter `DIV_W`;
  - inputs `clk`, `rst_n`, `clr`, `run`, `half_per`;
  - output `tone`;
  - contains the counter, terminal detect and toggle flop.
- `piezo_seq` holds the FSM, cadence counter, shadow registers and output flops.
- Integration: `dig_core` replaces its `pz_cnt` logic with `piezo_seq`, driving `en = in_transit & ~OK2Move` and `mode = PZ_CONT`.

## Test plan
Bench parameters: `BEEP_ON` = 20, `BEEP_OFF` = 10, `GAP_CYC` = 5.

1. Reset with `en` = 0 → `buzz` 0, `buzz_n` 1, `active` 0, `cycle_done` 0; all hold for 50 cycles.
2. CONT, `half_per_a` = 3, `en` rises → `active` next cycle; `buzz` rises 3 cycles after entry and toggles every 3 cycles; `cycle_done` every 20 cycles; first pulse 20 cycles after entry.
3. BEEP, H = 2 → 20-cycle toggling window then 10 cycles of `buzz` = 0, repeating; `cycle_done` period 30.
4. DBL, H = 2 → 20 on, 5 silent, 20 on, 10 silent; `cycle_done` period 55.
5. SIREN, a = 2, b = 5 → buzz period 4 for 20 cycles, then period 10 for 20 cycles. Switching `mode` to CONT mid-TONE1 has no effect until the next `cycle_done`. `half_per_a` = 0 → `buzz` stuck at 0 while `active` stays 1.
6. `en` dropped mid-TONE2 → IDLE after the next edge, `buzz` 0. `rst_n` pulsed low mid-TONE1 → immediate reset values; resumes at TONE1 one edge after release with `en` high.
